// File: rtl/router_fifo.sv
// Output-port FIFO of the 1x3 router: 16-deep byte store with lfd tags and a packet
// length counter that idles data_out between packets. Define ROUTER_FIFO_TRISTATE_EN to float an idle data_out.
module router_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-2:0] CNT_ONE = {{(DATA_WIDTH-2){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      lfd_tag;
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [DATA_WIDTH-2:0] pkt_cnt, pkt_cnt_nxt;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_tag;
  logic                  wr_fire, rd_fire;

  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_addr == rd_addr) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign wr_fire = write_enb && !full;
  assign rd_fire = read_enb && !empty;
  assign rd_data = mem[rd_addr];
  assign rd_tag  = lfd_tag[rd_addr];

  // A tagged header reloads the counter with payload length plus the parity byte.
  always_comb begin
    // NOTE: default assigned first so every path writes pkt_cnt_nxt; a missing else would infer a latch.
    pkt_cnt_nxt = pkt_cnt;
    if (rd_fire) begin
      if (rd_tag)
        pkt_cnt_nxt = {1'b0, rd_data[DATA_WIDTH-1:2]} + CNT_ONE;
      else if (pkt_cnt != '0)
        pkt_cnt_nxt = pkt_cnt - CNT_ONE;
    end
  end

  // NOTE: payload storage has no reset; the pointers and tags alone define what is valid.
  always_ff @(posedge clock) begin
    if (wr_fire && !soft_reset)
      mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lfd_tag <= '0;
      pkt_cnt <= '0;
      dout_q  <= '0;
    end else if (soft_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lfd_tag <= '0;
      pkt_cnt <= '0;
      dout_q  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr           <= wr_ptr + PTR_ONE;
        lfd_tag[wr_addr] <= lfd_state;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout_q <= rd_data;
      end else if (pkt_cnt == '0) begin
        dout_q <= '0;
      end
      pkt_cnt <= pkt_cnt_nxt;
    end
  end

`ifdef ROUTER_FIFO_TRISTATE_EN
  // Tracks whether data_out holds read data rather than the idle value, so a real 0x00 byte is still driven.
  logic out_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      out_valid <= 1'b0;
    else if (soft_reset)
      out_valid <= 1'b0;
    else if (rd_fire)
      out_valid <= 1'b1;
    else if (pkt_cnt == '0)
      out_valid <= 1'b0;
  end

  assign data_out = out_valid ? dout_q : {DATA_WIDTH{1'bz}};
`else
  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus a random run against a queue-based model.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of {tag, byte}, the packet byte countdown and the expected output.
  logic [8:0] q[$];
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_drv;

  router_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] exp_dout();
    return m_drv ? m_dout : IDLE;
  endfunction

  function automatic logic [4:0] occupancy();
    return dut.wr_ptr - dut.rd_ptr;
  endfunction

  task automatic model_clear();
    q.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    m_drv  = 1'b0;
  endtask

  // One clock: drive inputs, advance the model with pre-edge occupancy, settle 1 time unit past the edge.
  task automatic cycle(input bit we, input bit re, input bit lfd, input logic [7:0] din, input bit sr);
    bit         pre_empty, pre_full;
    logic [8:0] e;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = sr;
    pre_empty  = (q.size() == 0);
    pre_full   = (q.size() == 16);
    @(posedge clock);
    if (sr) begin
      model_clear();
    end else begin
      if (re && !pre_empty) begin
        e      = q.pop_front();
        m_dout = e[7:0];
        m_drv  = 1'b1;
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt--;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
        m_drv  = 1'b0;
      end
      if (we && !pre_full) q.push_back({lfd, din});
    end
    #1;
  endtask

  task automatic test_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (data_out !== IDLE) begin errors++; $display("FAIL reset_dout: got %h want %h", data_out, IDLE); end
    cycle(1, 0, 0, 8'h33, 0);
    cycle(1, 0, 0, 8'h44, 0);
    #2 resetn = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL async_reset_full: got %b want 0", full); end
    checks++; if (data_out !== IDLE) begin errors++; $display("FAIL async_reset_dout: got %h want %h", data_out, IDLE); end
    model_clear();
    @(negedge clock) resetn = 1'b1;
    cycle(1, 0, 0, 8'hA5, 0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL first_write_empty: got %b want 0", empty); end
    cycle(0, 1, 0, 8'h00, 0);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL first_read: got %h want a5", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_read_empty: got %b want 1", empty); end
  endtask

  task automatic test_fill_wrap();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 1; i <= 16; i++) begin
        cycle(1, 0, 0, 8'(i), 0);
        if (i == 15) begin
          checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill15_full: got %b want 0", full); end
        end
      end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill16_full rep%0d: got %b want 1", rep, full); end
      cycle(1, 0, 0, 8'hFF, 0);
      checks++; if (full !== 1'b1 || occupancy() !== 5'd16) begin
        errors++; $display("FAIL drop_full rep%0d: full=%b occ=%0d want 1/16", rep, full, occupancy());
      end
      for (int i = 1; i <= 16; i++) begin
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (data_out !== 8'(i)) begin
          errors++; $display("FAIL drain rep%0d idx%0d: got %h want %h", rep, i, data_out, 8'(i));
        end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty rep%0d: got %b want 1", rep, empty); end
      cycle(0, 0, 0, 8'h00, 0);
      checks++; if (data_out !== IDLE) begin errors++; $display("FAIL drain_idle rep%0d: got %h want %h", rep, data_out, IDLE); end
    end
  endtask

  task automatic test_packet();
    logic [7:0] bytes [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
    for (int i = 0; i < 5; i++) cycle(1, 0, (i == 0), bytes[i], 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 8'h00, 0);
      checks++; if (data_out !== bytes[i]) begin errors++; $display("FAIL pkt_byte%0d: got %h want %h", i, data_out, bytes[i]); end
      checks++; if (dut.pkt_cnt !== 7'(4 - i)) begin errors++; $display("FAIL pkt_cnt%0d: got %0d want %0d", i, dut.pkt_cnt, 4 - i); end
    end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (data_out !== IDLE) begin errors++; $display("FAIL pkt_idle: got %h want %h", data_out, IDLE); end
  endtask

  task automatic test_simul_rw();
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 8'h50 + 8'(i), 0);
      checks++; if (occupancy() !== 5'd8 || full !== 1'b0 || empty !== 1'b0 || data_out !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL simul%0d: occ=%0d full=%b empty=%b dout=%h want 8/0/0/%h",
                           i, occupancy(), full, empty, data_out, 8'h40 + 8'(i));
      end
    end
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'h60 + 8'(i), 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL simul_fill: got %b want 1", full); end
    cycle(1, 1, 0, 8'hEE, 0);
    checks++; if (occupancy() !== 5'd15 || full !== 1'b0 || data_out !== 8'h44) begin
      errors++; $display("FAIL simul_full: occ=%0d full=%b dout=%h want 15/0/44", occupancy(), full, data_out);
    end
  endtask

  task automatic test_soft_reset();
    cycle(0, 0, 0, 8'h00, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sr_flush_empty: got %b want 1", empty); end
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 8'h80 + 8'(i), 0);
    cycle(0, 1, 0, 8'h00, 0);
    cycle(0, 1, 0, 8'h00, 0);
    checks++; if (data_out !== 8'h81) begin errors++; $display("FAIL sr_pre_read: got %h want 81", data_out); end
    cycle(1, 0, 1, 8'h99, 1);
    checks++; if (empty !== 1'b1 || data_out !== IDLE || dut.pkt_cnt !== 7'd0) begin
      errors++; $display("FAIL sr_clear: empty=%b dout=%h cnt=%0d want 1/%h/0", empty, data_out, dut.pkt_cnt, IDLE);
    end
    cycle(0, 1, 0, 8'h00, 0);
    checks++; if (empty !== 1'b1 || data_out !== IDLE) begin
      errors++; $display("FAIL sr_write_absent: empty=%b dout=%h want 1/%h", empty, data_out, IDLE);
    end
  endtask

  task automatic test_zero_len();
    cycle(1, 0, 1, 8'h00, 0);
    cycle(1, 0, 0, 8'h77, 0);
    cycle(0, 1, 0, 8'h00, 0);
    checks++; if (data_out !== 8'h00 || dut.pkt_cnt !== 7'd1) begin
      errors++; $display("FAIL zl_hdr: dout=%h cnt=%0d want 00/1", data_out, dut.pkt_cnt);
    end
    cycle(0, 1, 0, 8'h00, 0);
    checks++; if (data_out !== 8'h77 || dut.pkt_cnt !== 7'd0) begin
      errors++; $display("FAIL zl_parity: dout=%h cnt=%0d want 77/0", data_out, dut.pkt_cnt);
    end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (data_out !== IDLE) begin errors++; $display("FAIL zl_idle: got %h want %h", data_out, IDLE); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), ($urandom_range(0, 5) == 0),
            8'($urandom), ($urandom_range(0, 59) == 0));
      checks++; if (empty !== (q.size() == 0) || full !== (q.size() == 16) ||
                    data_out !== exp_dout() || dut.pkt_cnt !== 7'(m_cnt)) begin
        errors++; $display("FAIL rand%0d: empty=%b full=%b dout=%h cnt=%0d want %b/%b/%h/%0d", n, empty, full,
                           data_out, dut.pkt_cnt, (q.size() == 0), (q.size() == 16), exp_dout(), m_cnt);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
    model_clear();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    test_reset();
    test_fill_wrap();
    test_packet();
    test_simul_rw();
    test_soft_reset();
    test_zero_len();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- One output-port FIFO of the 1x3 router; three instances sit directly downstream of the synchroniser.
- Each instance takes one bit of the synchroniser's write-enable bus plus its own soft reset, and stores packet bytes written from the input stage.
- It drives empty/full back to the synchroniser and presents bytes to the destination client on read_enb.
- It tracks packet boundaries internally, using a header tag and a length counter, so it can idle data_out between packets.

Parameters:
- DATA_WIDTH, 8, width of packet bytes; header byte carries length in bits [DATA_WIDTH-1:2] and destination in [1:0].
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH = 16 entries.

Ports:
- clock  input  1  single clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- soft_reset  input  1  synchronous flush from the synchroniser's 30-cycle timeout.
- write_enb  input  1  write request for this FIFO (one bit of the synchroniser's write_enb bus).
- read_enb  input  1  read request from the destination client.
- lfd_state  input  1  high on the cycle the header byte is written; tags that entry.
- data_in  input  DATA_WIDTH  byte to store.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  no free entry.
- empty  output  1  no stored entry.

Behaviour:
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH+1 bits; the extra bit holds the lfd tag.
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low ADDR_WIDTH bits equal and MSBs differ.
  - Both flags are combinational from registered pointers.
- Write: accepted when write_enb && !full. Stores {lfd_state, data_in} at wr_ptr[ADDR_WIDTH-1:0], then increments wr_ptr (wraps naturally).
- Write while full: dropped; no pointer change.
- Read: accepted when read_enb && !empty. data_out <= mem[rd_ptr] data bits one cycle later (1-cycle latency), then rd_ptr increments.
- Read while empty: ignored; data_out holds.
- Simultaneous read and write:
  - Both are evaluated against the pre-edge flags.
  - When empty, only the write happens.
  - When full, only the read happens.
  - Otherwise both happen and occupancy is unchanged.
- Packet counter pkt_cnt (DATA_WIDTH-1 bits):
  - On a read whose entry has the lfd tag set: pkt_cnt <= data[DATA_WIDTH-1:2] + 1 (payload bytes plus parity byte).
  - On any other accepted read while pkt_cnt != 0: pkt_cnt decrements.
  - It never underflows below 0.
- Idle output: when pkt_cnt == 0 and no read is accepted this cycle, data_out <= 0. Otherwise data_out holds its last value.
- Header with length 0: pkt_cnt = 1, i.e. header followed by parity only.
- soft_reset (synchronous, highest priority after resetn):
  - Clears wr_ptr, rd_ptr, pkt_cnt and data_out, and all lfd tags.
  - A write or read in the same cycle is discarded.
  - Memory data contents need not be cleared.
- resetn low (asynchronous): wr_ptr = 0, rd_ptr = 0, pkt_cnt = 0, data_out = 0, all lfd tags = 0. Hence empty = 1 and full = 0.
- Reset mid-packet: any partial packet is lost; the next write starts clean at entry 0.

Optional Feature:
- Macro ROUTER_FIFO_TRISTATE_EN.
- Defined: data_out is driven to high-impedance (all Z) whenever it would otherwise be 0 by rule. This covers idle with pkt_cnt == 0, soft_reset and resetn. It lets the three FIFOs share a bus.
- Undefined: data_out is driven to 0 in those cases; no Z values are ever produced.

Test Plan:
- Reset: resetn low mid-run -> immediately empty=1, full=0, data_out=0. After release, the first write of 0xA5 makes empty=0 on the next cycle.
- Fill/wrap: 16 writes 0x01..0x10 -> full=1 after the 16th. A 17th write of 0xFF is dropped. 16 reads return 0x01..0x10 in order, then empty=1. Repeat once more to exercise pointer wrap.
- Packet framing:
  - Write header 0x0C with lfd_state=1 (length 3), then payload 0x11, 0x22, 0x33 and parity 0x5A.
  - Read 5 bytes -> pkt_cnt goes 4,3,2,1,0 and data_out shows 0x0C,0x11,0x22,0x33,0x5A.
  - The next idle cycle -> data_out=0x00 (Z with the macro).
- Simultaneous R/W: with 8 entries held, assert read_enb and write_enb together for 4 cycles -> occupancy stays 8, full=0, empty=0. On full with both asserted -> one read, write dropped.
- Soft reset: after writing 6 bytes and reading 2, pulse soft_reset together with write_enb -> next cycle empty=1, data_out=0, pkt_cnt=0, and the concurrent write is absent.
- Zero-length header: header 0x00 with lfd_state=1 plus parity 0x77. Read both -> pkt_cnt 1 then 0; data_out 0x00, 0x77, then idle 0.
